cam_stream_gen: RTL and testbench



---
 rtl/cam_stream_gen.sv | 175 +++++++++++++++++
 tb/tb_cam_stream_gen.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_stream_gen.sv
// OV7670-style camera bus generator: reads RGB332 pixels and sends each as two RGB565 bytes.
// Build macro TEST_PATTERN_EN replaces frame-buffer pixels with eight vertical colour bars.
module cam_stream_gen #(
    parameter int unsigned WIDTH        = 176,
    parameter int unsigned HEIGHT       = 144,
    parameter int unsigned HBLANK       = 144,
    parameter int unsigned VSYNC_LINES  = 3,
    parameter int unsigned VBACK_LINES  = 17,
    parameter int unsigned VFRONT_LINES = 10,
    parameter int unsigned ADDR_W       = 15
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              START,
    output logic [ADDR_W-1:0] RD_ADDR,
    input  logic [7:0]        RD_DATA,
    output logic              PCLK,
    output logic              VSYNC,
    output logic              HREF,
    output logic [7:0]        DATA,
    output logic              BUSY,
    output logic              FRAME_DONE
);
    localparam int unsigned LINE_TICKS = 2 * WIDTH + HBLANK;
    localparam int unsigned MAX_VS_VB  = (VSYNC_LINES > VBACK_LINES) ? VSYNC_LINES : VBACK_LINES;
    localparam int unsigned MAX_ACT_VF = (HEIGHT > VFRONT_LINES) ? HEIGHT : VFRONT_LINES;
    localparam int unsigned MAX_LINES  = (MAX_VS_VB > MAX_ACT_VF) ? MAX_VS_VB : MAX_ACT_VF;
    localparam int unsigned TICK_W     = $clog2(LINE_TICKS);
    localparam int unsigned LINE_W     = $clog2(MAX_LINES + 1);

    typedef enum logic [2:0] {StIdle, StVs, StVb, StAct, StVf} state_e;

    state_e              state_q, state_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic                pclk_q, vsync_q, href_q, busy_q, done_q, done_d;
    logic [7:0]          data_q, pix_q, pix_src;
    logic [ADDR_W-1:0]   addr_q;
    logic                tick, line_end, phase_end, in_active;
    logic                fetch_first, fetch_next;
    int unsigned         phase_lines;
    logic [15:0]         px_new, px_held;

    function automatic logic [15:0] to565(input logic [7:0] p);
        return {p[7:5], p[7:6], p[4:2], p[4:2], p[1:0], p[1:0], p[0]};
    endfunction

    // Every edge that drops PCLK is a tick; all bus outputs move only here.
    assign tick = pclk_q;

    always_comb begin
        phase_lines = 1;
        unique case (state_q)
            StVs:    phase_lines = VSYNC_LINES;
            StVb:    phase_lines = VBACK_LINES;
            StAct:   phase_lines = HEIGHT;
            StVf:    phase_lines = VFRONT_LINES;
            default: phase_lines = 1;
        endcase
    end

    assign line_end  = (32'(tick_q) == LINE_TICKS - 1);
    assign phase_end = line_end && (32'(line_q) == phase_lines - 1);

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        line_d  = line_q;
        done_d  = 1'b0;
        if (tick) begin
            if (state_q == StIdle) begin
                tick_d = '0;
                line_d = '0;
                if (START) state_d = StVs;
            end else begin
                tick_d = line_end ? '0 : tick_q + 1'b1;
                if (line_end) line_d = phase_end ? '0 : line_q + 1'b1;
                if (phase_end) begin
                    unique case (state_q)
                        StVs:  state_d = StVb;
                        StVb:  state_d = StAct;
                        StAct: state_d = StVf;
                        StVf: begin
                            done_d  = 1'b1;
                            state_d = START ? StVs : StIdle;
                        end
                        default: state_d = StIdle;
                    endcase
                end
            end
        end
    end

    assign in_active = (state_d == StAct) && (32'(tick_d) < 2 * WIDTH);

`ifdef TEST_PATTERN_EN
    logic [2:0] bar_idx;
    logic       unused_rd_data;

    assign unused_rd_data = ^RD_DATA;
    assign fetch_first    = 1'b0;
    assign fetch_next     = 1'b0;

    always_comb begin
        bar_idx = 3'((32'(tick_d >> 1) * 8) / WIDTH);
        unique case (bar_idx)
            3'd0:    pix_src = 8'hFF;
            3'd1:    pix_src = 8'hFC;
            3'd2:    pix_src = 8'h1F;
            3'd3:    pix_src = 8'h1C;
            3'd4:    pix_src = 8'hE3;
            3'd5:    pix_src = 8'hE0;
            3'd6:    pix_src = 8'h03;
            default: pix_src = 8'h00;
        endcase
    end
`else
    assign pix_src = RD_DATA;

    // Address leads the byte0 tick by one tick so the 1-CLK read lands in time.
    always_comb begin
        fetch_first = (state_d == StVb) && (32'(line_d) == VBACK_LINES - 1)
                      && (32'(tick_d) == LINE_TICKS - 1);
        fetch_next  = (state_d == StAct)
                      && ((tick_d[0] && (32'(tick_d) < 2 * WIDTH - 1))
                          || ((32'(tick_d) == LINE_TICKS - 1) && (32'(line_d) < HEIGHT - 1)));
    end
`endif

    assign px_new  = to565(pix_src);
    assign px_held = to565(pix_q);

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q <= StIdle;
            tick_q  <= '0;
            line_q  <= '0;
            pclk_q  <= 1'b0;
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            data_q  <= '0;
            pix_q   <= '0;
            addr_q  <= '0;
        end else begin
            pclk_q  <= ~pclk_q;
            done_q  <= done_d;
            state_q <= state_d;
            tick_q  <= tick_d;
            line_q  <= line_d;
            if (tick) begin
                vsync_q <= (state_d == StVs);
                href_q  <= in_active;
                busy_q  <= (state_d != StIdle);
                if (in_active) begin
                    data_q <= tick_d[0] ? px_held[7:0] : px_new[15:8];
                    if (!tick_d[0]) pix_q <= pix_src;
                end else begin
                    data_q <= '0;
                end
                if (fetch_first) addr_q <= '0;
                else if (fetch_next) addr_q <= addr_q + 1'b1;
            end
        end
    end

    assign PCLK       = pclk_q;
    assign VSYNC      = vsync_q;
    assign HREF       = href_q;
    assign DATA       = data_q;
    assign BUSY       = busy_q;
    assign FRAME_DONE = done_q;
    assign RD_ADDR    = addr_q;
endmodule

// File: tb/tb_cam_stream_gen.sv
// Self-checking bench for cam_stream_gen against a schedule-based frame model.
module tb_cam_stream_gen;
`ifdef TEST_PATTERN_EN
    localparam int W = 8;
`else
    localparam int W = 4;
`endif
    localparam int H   = 2;
    localparam int HB  = 3;
    localparam int VSL = 1;
    localparam int VBL = 1;
    localparam int VFL = 1;
    localparam int AW  = 8;
    localparam int LT  = 2 * W + HB;
    localparam int FT  = (VSL + VBL + H + VFL) * LT;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data = 8'h00;
    logic          pclk, vsync, href, busy, frame_done;
    logic [7:0]    data;

    logic [7:0] mem [0:63];
    logic [7:0] cap [0:15];
    logic [7:0] req [0:15];
    int cap_n, vs_ticks, rise0, rise1, done_c;
    int n_cmp = 0;
    int n_fail = 0;

    typedef struct {
        bit       pclk, vsync, href, busy, done, addr_chk;
        bit [7:0] data;
        int       addr;
    } exp_t;

    cam_stream_gen #(
        .WIDTH(W), .HEIGHT(H), .HBLANK(HB), .VSYNC_LINES(VSL), .VBACK_LINES(VBL),
        .VFRONT_LINES(VFL), .ADDR_W(AW)
    ) dut (
        .CLK(clk), .RESET_N(rst_n), .START(start), .RD_ADDR(rd_addr), .RD_DATA(rd_data),
        .PCLK(pclk), .VSYNC(vsync), .HREF(href), .DATA(data), .BUSY(busy),
        .FRAME_DONE(frame_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) rd_data <= mem[rd_addr[5:0]];

    function automatic bit [7:0] pixel_at(int y, int x);
`ifdef TEST_PATTERN_EN
        case ((x * 8) / W)
            0: return 8'hFF;
            1: return 8'hFC;
            2: return 8'h1F;
            3: return 8'h1C;
            4: return 8'hE3;
            5: return 8'hE0;
            6: return 8'h03;
            default: return 8'h00;
        endcase
`else
        return mem[y * W + x];
`endif
    endfunction

    function automatic bit [7:0] enc_byte(bit [7:0] p, bit second);
        int r, g, b, r5, g6, b5;
        r = int'(p[7:5]); g = int'(p[4:2]); b = int'(p[1:0]);
        r5 = r * 4 + r / 2;
        g6 = g * 9;
        b5 = b * 10 + b % 2;
        if (!second) return 8'(r5 * 8 + g6 / 8);
        return 8'((g6 % 8) * 32 + b5);
    endfunction

    // Expected bus state at sample c (c=0 is the CLK right after the frame's first tick).
    function automatic exp_t model_at(int c, int nframes);
        exp_t e;
        int f, cc, k, rel, y, t;
        e.pclk = (c % 2) == 1; e.vsync = 0; e.href = 0; e.busy = 0; e.done = 0;
        e.addr_chk = 0; e.data = 8'h00; e.addr = 0;
        f = c / (2 * FT); cc = c % (2 * FT); k = cc / 2;
        e.done = (cc == 0) && (c > 0) && (f <= nframes);
        if (f >= nframes) return e;
        e.busy  = 1;
        e.vsync = k < VSL * LT;
        rel = k - (VSL + VBL) * LT;
        if (rel >= 0 && rel < H * LT) begin
            y = rel / LT; t = rel % LT;
            if (t < 2 * W) begin
                e.href = 1;
                e.data = enc_byte(pixel_at(y, t / 2), (t % 2) == 1);
                if (t % 2 == 0) begin
                    e.addr_chk = 1;
`ifdef TEST_PATTERN_EN
                    e.addr = 0;
`else
                    e.addr = y * W + t / 2;
`endif
                end
            end
        end
        return e;
    endfunction

    task automatic align_tick();
        int n = 0;
        @(negedge clk);
        while (pclk !== 1'b1 && n < 4) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (pclk !== 1'b1) begin
            n_fail++;
            $display("FAIL align: pclk=%b, required 1 within 4 CLK", pclk);
        end
    endtask

    task automatic scan_frames(input string tag, input int nframes, input bit hold);
        exp_t e;
        bit prev_href = 0;
        align_tick();
        start = 1'b1;
        vs_ticks = 0; rise0 = -1; rise1 = -1; done_c = -1; cap_n = 0;
        for (int c = 0; c < 2 * FT * nframes + 4; c++) begin
            @(negedge clk);
            if (!hold && c == 0) start = 1'b0;
            if (hold && c == 2 * FT * (nframes - 1)) start = 1'b0;
            e = model_at(c, nframes);
            n_cmp++;
            if ({pclk, vsync, href, busy, frame_done} !== {e.pclk, e.vsync, e.href, e.busy, e.done}
                || data !== e.data) begin
                n_fail++;
                $display("FAIL %s c=%0d: pclk/vs/href/busy/done=%b%b%b%b%b data=%h, required %b%b%b%b%b %h",
                         tag, c, pclk, vsync, href, busy, frame_done, data,
                         e.pclk, e.vsync, e.href, e.busy, e.done, e.data);
            end
            if (e.addr_chk) begin
                n_cmp++;
                if (rd_addr !== AW'(e.addr)) begin
                    n_fail++;
                    $display("FAIL %s_addr c=%0d: rd_addr=%0d, required %0d", tag, c, rd_addr, e.addr);
                end
            end
            if (c < 2 * FT && c % 2 == 0) begin
                if (vsync === 1'b1) vs_ticks++;
                if (href === 1'b1 && !prev_href) begin
                    if (rise0 < 0) rise0 = c / 2;
                    else if (rise1 < 0) rise1 = c / 2;
                end
                prev_href = (href === 1'b1);
                if (href === 1'b1 && cap_n < 16) begin
                    cap[cap_n] = data;
                    cap_n++;
                end
            end
            if (frame_done === 1'b1 && done_c < 0) done_c = c;
        end
    endtask

    task automatic test_reset();
        logic prev;
        rst_n = 1'b0;
        start = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp++;
        if ({pclk, vsync, href, busy, frame_done} !== 5'b0 || data !== 8'h00 || rd_addr !== '0) begin
            n_fail++;
            $display("FAIL reset_values: pclk/vs/href/busy/done=%b%b%b%b%b data=%h addr=%0d, required all 0",
                     pclk, vsync, href, busy, frame_done, data, rd_addr);
        end
        rst_n = 1'b1;
        prev = pclk;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            n_cmp++;
            if (pclk === prev || vsync !== 1'b0 || href !== 1'b0 || data !== 8'h00 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL idle i=%0d: pclk=%b(prev %b) vs=%b href=%b data=%h busy=%b, required toggle and 0s",
                         i, pclk, prev, vsync, href, data, busy);
            end
            prev = pclk;
        end
    endtask

    task automatic test_single_frame();
        for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
        scan_frames("single", 1, 1'b0);
        n_cmp++;
        if (vs_ticks != VSL * LT) begin
            n_fail++;
            $display("FAIL vsync_len: %0d ticks, required %0d", vs_ticks, VSL * LT);
        end
        n_cmp++;
        if (rise0 != (VSL + VBL) * LT || rise1 != (VSL + VBL + 1) * LT) begin
            n_fail++;
            $display("FAIL href_rise: ticks %0d,%0d, required %0d,%0d", rise0, rise1,
                     (VSL + VBL) * LT, (VSL + VBL + 1) * LT);
        end
        n_cmp++;
        if (done_c != 2 * FT) begin
            n_fail++;
            $display("FAIL frame_done_time: CLK %0d, required %0d", done_c, 2 * FT);
        end
        repeat (6) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_after: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_colour_decode();
        int n;
`ifdef TEST_PATTERN_EN
        req = '{8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'h07, 8'hFF, 8'h07, 8'hE0,
                8'hF8, 8'h1F, 8'hF8, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h00};
        n = 16;
`else
        req = '{8'hF8, 8'h00, 8'h07, 8'hE0, 8'h00, 8'h1F, 8'hFF, 8'hFF,
                8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        n = 8;
`endif
        for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
        mem[0] = 8'hE0; mem[1] = 8'h1C; mem[2] = 8'h03; mem[3] = 8'hFF;
        scan_frames("colour", 1, 1'b0);
        for (int i = 0; i < n; i++) begin
            n_cmp++;
            if (cap[i] !== req[i]) begin
                n_fail++;
                $display("FAIL colour_byte%0d: data=%h, required %h", i, cap[i], req[i]);
            end
        end
    endtask

    task automatic test_random_frames();
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
            repeat ($urandom_range(0, 7)) @(negedge clk);
            scan_frames("random", 1, 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
        scan_frames("back_to_back", 2, 1'b1);
    endtask

    task automatic test_reset_mid_frame();
        int target;
        target = 2 * ((VSL + VBL + 1) * LT + 3);
        align_tick();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= target; c++) @(negedge clk);
        n_cmp++;
        if (href !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_precond: href=%b, required 1", href);
        end
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({pclk, vsync, href, busy, frame_done} !== 5'b0 || data !== 8'h00 || rd_addr !== '0) begin
            n_fail++;
            $display("FAIL mid_reset: pclk/vs/href/busy/done=%b%b%b%b%b data=%h addr=%0d, required all 0",
                     pclk, vsync, href, busy, frame_done, data, rd_addr);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        scan_frames("after_reset", 1, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
        test_reset();
        test_single_frame();
        test_colour_decode();
        test_random_frames();
        test_back_to_back();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
